// File: rtl/if_fetch_if.sv
// Instruction bus between the fetch stage and the instruction memory:
// one request outstanding, address phase by req/gnt, data phase by rvalid.
interface if_fetch_if;
  logic        req;
  logic [31:0] addr;
  logic        gnt;
  logic        rvalid;
  logic [31:0] rdata;

  modport master (output req, addr, input gnt, rvalid, rdata);
  modport slave  (input req, addr, output gnt, rvalid, rdata);
endinterface

// File: rtl/if_fetch.sv
// MIPS32 instruction-fetch stage: owns the fetch PC, issues single-outstanding bus reads,
// buffers returned words in an ID slot plus one skid entry, and applies branch/flush redirects.
module if_fetch #(
  parameter logic [31:0] RESET_PC = 32'hBFC00000,
  parameter int unsigned ADEL_BIT = 13
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall_i,
  input  logic              flush_i,
  input  logic [31:0]       new_pc_i,
  input  logic              branch_flag_i,
  input  logic [31:0]       branch_target_address_i,
  if_fetch_if.master        ibus,
  output logic              id_valid_o,
  output logic [31:0]       id_pc_o,
  output logic [31:0]       id_inst_o,
  output logic [31:0]       id_excepttype_o,
  output logic              stallreq_o
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_WAIT = 2'd2;
  localparam logic [1:0] S_HALT = 2'd3;

  logic [1:0]  state, state_nxt;
  logic [31:0] fetch_pc, fetch_pc_nxt;
  logic [31:0] addr_q;
  logic [31:0] br_tgt;
  logic        br_pending, br_pending_nxt;
  logic        discard, discard_nxt;

  logic        slot_valid, slot_adel;
  logic [31:0] slot_pc, slot_inst;
  logic        skid_valid, skid_adel;
  logic [31:0] skid_pc, skid_inst;

  logic        accept, granted, misaligned;
  logic        br_take, br_defer, br_now;
  logic        enq_valid, enq_adel;
  logic [31:0] enq_pc, enq_inst;

  always_comb begin
    accept     = slot_valid & ~stall_i & ~flush_i;
    granted    = (state == S_REQ) & ibus.gnt;
    misaligned = (fetch_pc[1:0] != 2'b00);
    br_take    = accept & branch_flag_i;
    // Delay slot not yet granted: remember the target and let its grant do the redirect.
    br_defer   = br_take & (fetch_pc == slot_pc + 32'd4);
    br_now     = br_take & ~br_defer;

    enq_valid = 1'b0;
    enq_adel  = 1'b0;
    enq_pc    = addr_q;
    enq_inst  = ibus.rdata;
    if (!flush_i) begin
      if (state == S_WAIT && ibus.rvalid && !discard) begin
        enq_valid = 1'b1;
      end else if (state == S_IDLE && !skid_valid && misaligned) begin
        enq_valid = 1'b1;
        enq_adel  = 1'b1;
        enq_pc    = fetch_pc;
        enq_inst  = '0;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (!skid_valid) state_nxt = misaligned ? S_HALT : S_REQ;
      S_REQ:  if (ibus.gnt) state_nxt = S_WAIT;
      S_WAIT: if (ibus.rvalid) state_nxt = S_IDLE;
      default: state_nxt = S_HALT;
    endcase
    if (flush_i && (state == S_IDLE || state == S_HALT)) state_nxt = S_IDLE;

    // A flushed request still completes on the bus; its word is thrown away on return.
    discard_nxt = discard;
    if (flush_i) begin
      if (state == S_REQ)       discard_nxt = 1'b1;
      else if (state == S_WAIT) discard_nxt = ~ibus.rvalid;
    end else if (state == S_WAIT && ibus.rvalid) begin
      discard_nxt = 1'b0;
    end

    fetch_pc_nxt   = fetch_pc;
    br_pending_nxt = br_pending;
    if (flush_i) begin
      fetch_pc_nxt   = new_pc_i;
      br_pending_nxt = 1'b0;
    end else begin
      if (granted && !discard) begin
        if (br_pending) begin
          fetch_pc_nxt   = br_tgt;
          br_pending_nxt = 1'b0;
        end else if (br_defer) begin
          fetch_pc_nxt = branch_target_address_i;
        end else begin
          fetch_pc_nxt = fetch_pc + 32'd4;
        end
      end else if (br_defer) begin
        br_pending_nxt = 1'b1;
      end
      if (br_now) fetch_pc_nxt = branch_target_address_i;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= S_IDLE;
      fetch_pc   <= RESET_PC;
      addr_q     <= '0;
      br_tgt     <= '0;
      br_pending <= 1'b0;
      discard    <= 1'b0;
    end else begin
      state      <= state_nxt;
      fetch_pc   <= fetch_pc_nxt;
      br_pending <= br_pending_nxt;
      discard    <= discard_nxt;
      if (state == S_IDLE && state_nxt == S_REQ) addr_q <= fetch_pc;
      if (br_defer) br_tgt <= branch_target_address_i;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      slot_valid <= 1'b0;
      slot_adel  <= 1'b0;
      slot_pc    <= '0;
      slot_inst  <= '0;
      skid_valid <= 1'b0;
      skid_adel  <= 1'b0;
      skid_pc    <= '0;
      skid_inst  <= '0;
    end else if (flush_i) begin
      slot_valid <= 1'b0;
      skid_valid <= 1'b0;
    end else if (accept || !slot_valid) begin
      if (skid_valid) begin
        slot_valid <= 1'b1;
        slot_pc    <= skid_pc;
        slot_inst  <= skid_inst;
        slot_adel  <= skid_adel;
        skid_valid <= enq_valid;
        if (enq_valid) begin
          skid_pc   <= enq_pc;
          skid_inst <= enq_inst;
          skid_adel <= enq_adel;
        end
      end else begin
        slot_valid <= enq_valid;
        if (enq_valid) begin
          slot_pc   <= enq_pc;
          slot_inst <= enq_inst;
          slot_adel <= enq_adel;
        end
      end
    end else if (enq_valid) begin
      skid_valid <= 1'b1;
      skid_pc    <= enq_pc;
      skid_inst  <= enq_inst;
      skid_adel  <= enq_adel;
    end
  end

  assign ibus.req        = (state == S_REQ);
  assign ibus.addr       = addr_q;
  assign id_valid_o      = slot_valid;
  assign id_pc_o         = slot_pc;
  assign id_inst_o       = slot_valid ? slot_inst : '0;
  assign id_excepttype_o = (slot_valid && slot_adel) ? (32'd1 << ADEL_BIT) : '0;
  assign stallreq_o      = rst & ~slot_valid;

endmodule
